// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the I/D pipeline requesters, the arbiter and the shared memory bus.
// The arbiter takes the master view; the environment (pipeline + bus) takes the slave view.
interface mem_bus_arbiter_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwrite;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] baddr;
    logic        breq;
    logic        bwrite;
    logic [1:0]  bsize;
    logic [31:0] bwdata;
    logic        bbusy;
    logic        bready_n;
    logic [31:0] brdata;
    logic [31:0] rdata;
    logic        i_done;
    logic        d_done;
    logic        i_stall;
    logic        d_stall;

    modport master (
        input  ireq, iaddr, dreq, dwrite, dsize, daddr, dwdata,
        input  bbusy, bready_n, brdata,
        output baddr, breq, bwrite, bsize, bwdata,
        output rdata, i_done, d_done, i_stall, d_stall
    );

    modport slave (
        output ireq, iaddr, dreq, dwrite, dsize, daddr, dwdata,
        output bbusy, bready_n, brdata,
        input  baddr, breq, bwrite, bsize, bwdata,
        input  rdata, i_done, d_done, i_stall, d_stall
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (I) and memory-access (D); D has priority,
// a starvation counter forces an I grant after STARVE_MAX back-to-back D grants.
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       i_elig;
    logic       d_elig;

    // A side whose done pulse is high is finishing, not asking again.
    assign i_elig      = bus.ireq & ~bus.i_done;
    assign d_elig      = bus.dreq & ~bus.d_done;
    assign bus.i_stall = bus.ireq & ~bus.i_done;
    assign bus.d_stall = bus.dreq & ~bus.d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            bus.baddr  <= '0;
            bus.breq   <= 1'b0;
            bus.bwrite <= 1'b0;
            bus.bsize  <= '0;
            bus.bwdata <= '0;
            bus.rdata  <= '0;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            if (!bus.ireq) begin
                starve_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (!bus.bbusy) begin
                        if (i_elig && (starve_cnt == STARVE_LIM || !d_elig)) begin
                            state      <= GNT_I;
                            bus.baddr  <= bus.iaddr;
                            bus.breq   <= 1'b1;
                            bus.bwrite <= 1'b0;
                            bus.bsize  <= 2'b10;
                            bus.bwdata <= '0;
                        end else if (d_elig) begin
                            state      <= GNT_D;
                            bus.baddr  <= bus.daddr;
                            bus.breq   <= 1'b1;
                            bus.bwrite <= bus.dwrite;
                            bus.bsize  <= bus.dsize;
                            bus.bwdata <= bus.dwdata;
                        end
                    end
                end
                GNT_D, GNT_I: begin
                    // Bus registers are frozen until the slave completes the transfer.
                    if (!bus.bready_n) begin
                        state      <= IDLE;
                        bus.rdata  <= bus.brdata;
                        bus.baddr  <= '0;
                        bus.breq   <= 1'b0;
                        bus.bwrite <= 1'b0;
                        bus.bsize  <= '0;
                        bus.bwdata <= '0;
                        if (state == GNT_I) begin
                            bus.i_done <= 1'b1;
                            starve_cnt <= '0;
                        end else begin
                            bus.d_done <= 1'b1;
                            if (bus.ireq && starve_cnt != STARVE_LIM) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a scoreboard holds the expected grant order and
// read data, a bus responder model answers transfers, and each step checks timing points.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        side_i;
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk;
    logic rst;
    mem_bus_arbiter_if bus_if ();

    int   n_checks;
    int   n_errors;
    txn_t exp_grant_q[$];
    txn_t exp_done_q[$];

    int          resp_lat;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        use_override;
    logic [31:0] override_val;
    logic        force_busy;
    logic        busy_on_done;
    logic        force_ready;

    mem_bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    assign bus_if.bbusy    = force_busy | (busy_on_done & bus_if.d_done);
    assign bus_if.bready_n = ~(force_ready | resp_ready);
    assign bus_if.brdata   = force_ready ? 32'hBAD0_BAD0 : resp_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic side_i, input logic [31:0] addr, input logic write,
                            input logic [1:0] size, input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.side_i = side_i;
        t.addr   = addr;
        t.write  = write;
        t.size   = size;
        t.wdata  = wdata;
        t.rdata  = rdata;
        exp_grant_q.push_back(t);
    endtask

    task automatic wait_done(input logic side_i, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(side_i ? bus_if.i_done : bus_if.d_done) && n < 60);
        check_output({tag, "_timeout"}, 32'(side_i ? bus_if.i_done : bus_if.d_done), 32'd1);
    endtask

    // Bus slave: completes a transfer resp_lat cycles after breq is first seen.
    initial begin
        int cnt;
        cnt        = 0;
        resp_ready = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            resp_ready = 1'b0;
            if (!rst || !bus_if.breq) begin
                cnt = 0;
            end else if (cnt >= resp_lat) begin
                resp_ready = 1'b1;
                resp_data  = use_override ? override_val : rd_fn(bus_if.baddr);
                cnt        = 0;
            end else begin
                cnt++;
            end
        end
    end

    // Scoreboard monitor: grant order, bus stability while granted, done side and read data.
    initial begin
        logic prev_breq;
        txn_t held;
        txn_t t;
        prev_breq = 1'b0;
        held      = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_done_q.delete();
                prev_breq = 1'b0;
            end else begin
                if (bus_if.breq && !prev_breq) begin
                    if (exp_grant_q.size() == 0) begin
                        check_output("unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        t = exp_grant_q.pop_front();
                        check_output("grant_addr",  bus_if.baddr, t.addr);
                        check_output("grant_write", 32'(bus_if.bwrite), 32'(t.write));
                        check_output("grant_size",  32'(bus_if.bsize), 32'(t.size));
                        check_output("grant_wdata", bus_if.bwdata, t.wdata);
                        exp_done_q.push_back(t);
                        held = t;
                    end
                end else if (bus_if.breq) begin
                    check_output("hold_addr",  bus_if.baddr, held.addr);
                    check_output("hold_write", 32'(bus_if.bwrite), 32'(held.write));
                    check_output("hold_size",  32'(bus_if.bsize), 32'(held.size));
                    check_output("hold_wdata", bus_if.bwdata, held.wdata);
                end
                if (bus_if.i_done || bus_if.d_done) begin
                    check_output("done_exclusive", 32'(bus_if.i_done & bus_if.d_done), 32'd0);
                    if (exp_done_q.size() == 0) begin
                        check_output("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        t = exp_done_q.pop_front();
                        check_output("done_i_side", 32'(bus_if.i_done), 32'(t.side_i));
                        check_output("done_rdata",  bus_if.rdata, t.rdata);
                    end
                end
                prev_breq = bus_if.breq;
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b0;
        resp_lat       = 0;
        use_override   = 1'b0;
        override_val   = '0;
        force_busy     = 1'b0;
        busy_on_done   = 1'b0;
        force_ready    = 1'b0;
        bus_if.ireq    = 1'b0;
        bus_if.iaddr   = '0;
        bus_if.dreq    = 1'b0;
        bus_if.dwrite  = 1'b0;
        bus_if.dsize   = 2'b10;
        bus_if.daddr   = '0;
        bus_if.dwdata  = '0;

        repeat (3) @(negedge clk);
        check_output("rst_breq",   32'(bus_if.breq), 32'd0);
        check_output("rst_baddr",  bus_if.baddr, 32'd0);
        check_output("rst_rdata",  bus_if.rdata, 32'd0);
        check_output("rst_i_done", 32'(bus_if.i_done), 32'd0);
        check_output("rst_d_done", 32'(bus_if.d_done), 32'd0);
        rst = 1'b1;

        // Step 1: single D read, bready_n low two cycles after breq.
        @(negedge clk);
        $display("[TB] step 1: D read latency");
        resp_lat     = 2;
        use_override = 1'b1;
        override_val = 32'hDEAD_BEEF;
        push_txn(1'b0, 32'h100, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF);
        bus_if.daddr = 32'h100;
        bus_if.dreq  = 1'b1;
        #1;
        check_output("t1_stall_c0", 32'(bus_if.d_stall), 32'd1);
        check_output("t1_breq_c0",  32'(bus_if.breq), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_output("t1_stall", 32'(bus_if.d_stall), 32'd1);
            check_output("t1_no_done", 32'(bus_if.d_done), 32'd0);
            if (c == 1) check_output("t1_breq_c1", 32'(bus_if.breq), 32'd1);
        end
        @(negedge clk);
        check_output("t1_done_c4",  32'(bus_if.d_done), 32'd1);
        check_output("t1_rdata_c4", bus_if.rdata, 32'hDEAD_BEEF);
        check_output("t1_stall_c4", 32'(bus_if.d_stall), 32'd0);
        bus_if.dreq  = 1'b0;
        use_override = 1'b0;

        // Step 2: simultaneous requests, D first, I in the cycle of d_done.
        @(negedge clk);
        $display("[TB] step 2: simultaneous I and D");
        resp_lat = 0;
        push_txn(1'b0, 32'h200, 1'b0, 2'b10, 32'h0, rd_fn(32'h200));
        push_txn(1'b1, 32'h400, 1'b0, 2'b10, 32'h0, rd_fn(32'h400));
        bus_if.daddr = 32'h200;
        bus_if.iaddr = 32'h400;
        bus_if.dreq  = 1'b1;
        bus_if.ireq  = 1'b1;
        wait_done(1'b0, "t2_d");
        check_output("t2_i_stalled", 32'(bus_if.i_stall), 32'd1);
        bus_if.dreq = 1'b0;
        @(negedge clk);
        check_output("t2_i_breq",  32'(bus_if.breq), 32'd1);
        check_output("t2_i_baddr", bus_if.baddr, 32'h400);
        check_output("t2_i_bsize", 32'(bus_if.bsize), 32'd2);
        wait_done(1'b1, "t2_i");
        bus_if.ireq = 1'b0;

        // Step 3: starvation, two rounds of four D grants then one I grant.
        @(negedge clk);
        $display("[TB] step 3: starvation counter");
        resp_lat     = 1;
        busy_on_done = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_txn(1'b0, 32'h300, 1'b0, 2'b10, 32'h0, rd_fn(32'h300));
            push_txn(1'b1, 32'h500, 1'b0, 2'b10, 32'h0, rd_fn(32'h500));
        end
        bus_if.daddr = 32'h300;
        bus_if.iaddr = 32'h500;
        bus_if.dreq  = 1'b1;
        bus_if.ireq  = 1'b1;
        for (int r = 0; r < 2; r++) begin
            repeat (4) wait_done(1'b0, "t3_d");
            wait_done(1'b1, "t3_i");
        end
        bus_if.dreq  = 1'b0;
        bus_if.ireq  = 1'b0;
        busy_on_done = 1'b0;

        // Step 4: D write, bus registers hold while the requester changes its inputs.
        @(negedge clk);
        $display("[TB] step 4: D write");
        resp_lat = 3;
        push_txn(1'b0, 32'h600, 1'b1, 2'b00, 32'h1234_5678, rd_fn(32'h600));
        bus_if.daddr  = 32'h600;
        bus_if.dwrite = 1'b1;
        bus_if.dsize  = 2'b00;
        bus_if.dwdata = 32'h1234_5678;
        bus_if.dreq   = 1'b1;
        @(negedge clk);
        bus_if.daddr  = 32'h700;
        bus_if.dsize  = 2'b11;
        bus_if.dwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_output("t4_bwdata", bus_if.bwdata, 32'h1234_5678);
        check_output("t4_bwrite", 32'(bus_if.bwrite), 32'd1);
        check_output("t4_bsize",  32'(bus_if.bsize), 32'd0);
        wait_done(1'b0, "t4_d");
        bus_if.dreq   = 1'b0;
        bus_if.dwrite = 1'b0;
        bus_if.dsize  = 2'b10;
        bus_if.dwdata = '0;

        // Step 5: bus busy for five cycles delays the grant.
        @(negedge clk);
        $display("[TB] step 5: bbusy");
        resp_lat   = 0;
        force_busy = 1'b1;
        push_txn(1'b0, 32'h800, 1'b0, 2'b10, 32'h0, rd_fn(32'h800));
        bus_if.daddr = 32'h800;
        bus_if.dreq  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_output("t5_breq_busy", 32'(bus_if.breq), 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        check_output("t5_breq_free", 32'(bus_if.breq), 32'd1);
        wait_done(1'b0, "t5_d");
        bus_if.dreq = 1'b0;

        // bready_n pulse while idle must be ignored.
        @(negedge clk);
        force_ready = 1'b1;
        @(negedge clk);
        force_ready = 1'b0;
        check_output("idle_ready_rdata", bus_if.rdata, rd_fn(32'h800));
        check_output("idle_ready_done",  32'(bus_if.d_done | bus_if.i_done), 32'd0);
        check_output("idle_ready_breq",  32'(bus_if.breq), 32'd0);

        // Step 6: reset in the middle of a D transfer.
        @(negedge clk);
        $display("[TB] step 6: reset mid-transfer");
        resp_lat = 20;
        push_txn(1'b0, 32'h900, 1'b0, 2'b10, 32'h0, rd_fn(32'h900));
        bus_if.daddr = 32'h900;
        bus_if.dreq  = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t6_breq_before", 32'(bus_if.breq), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_output("t6_breq_async", 32'(bus_if.breq), 32'd0);
        check_output("t6_baddr_async", bus_if.baddr, 32'd0);
        bus_if.dreq = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (25) @(negedge clk);
        check_output("t6_idle_breq", 32'(bus_if.breq), 32'd0);
        check_output("t6_rdata_kept_reset", bus_if.rdata, 32'd0);

        // Recovery: plain I fetch after the reset.
        resp_lat = 0;
        push_txn(1'b1, 32'hA00, 1'b0, 2'b10, 32'h0, rd_fn(32'hA00));
        bus_if.iaddr = 32'hA00;
        bus_if.ireq  = 1'b1;
        wait_done(1'b1, "t6_i");
        bus_if.ireq = 1'b0;

        repeat (3) @(negedge clk);
        check_output("sb_grant_empty", 32'(exp_grant_q.size()), 32'd0);
        check_output("sb_done_empty",  32'(exp_done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
